idli_fetch_m: RTL and testbench
===============================

# idli_fetch_m

Nibble-serial instruction fetch stage sitting between the SQI memory controller (`idli_sqi_ctrl_m`) and the core's decode stage. It does four things:
- supplies the 16-bit fetch address nibbles the controller shifts out to the SQI SRAM;
- assembles the 4-nibble read stream returned by the controller into 16-bit instructions tagged with their PC;
- buffers those instructions in a small queue for the core;
- requests a controller redirect on a branch or on queue overflow.

## Interface
Parameters:
- RESET_PC, 16'h0000: fetch address and PC after reset.

Ports:
- i_fetch_gck  in  1  gated core clock; the only clock.
- i_fetch_rst  in  1  reset; synchronous, active-high.
- i_fetch_ctr  in  2  nibble index within the current word; 0 = most-significant nibble.
- i_fetch_ctr_last_cycle  in  1  high in the last nibble cycle of each word (ctr == 3).
- i_fetch_rd_data  in  4  read nibble from the controller's o_sqi_rd_data.
- o_fetch_redirect  out  1  to the controller's i_sqi_redirect.
- o_fetch_addr_nib  out  4  address nibble to the controller's i_sqi_wr_data.
- i_fetch_branch  in  1  core branch request; sampled only when i_fetch_ctr_last_cycle is high.
- i_fetch_branch_pc  in  16  branch target byte address; must be even.
- o_fetch_vld  out  1  queue head is valid.
- o_fetch_instr  out  16  queue head instruction.
- o_fetch_pc  out  16  byte address of the queue head instruction.
- i_fetch_ack  in  1  core consumes the queue head; effective only when last_cycle & o_fetch_vld.

## Operation
- Phase tracker mirrors the controller: CMD -> ADDR -> DUMMY -> DATA.
  - Advances only on last_cycle.
  - DATA -> CMD only when o_fetch_redirect is high on last_cycle; otherwise DATA -> DATA.
- o_fetch_addr_nib:
  - In CMD: addr_q[15-4*ctr -: 4], MSN first.
  - Outside CMD: 4'h0.
- Read alignment: the controller double-buffers, so the nibbles sampled in DATA word k appear on i_fetch_rd_data during word k+1.
  - rx_vld = current phase DATA & previous-word phase DATA & ~pending_q.
- Assembly: a 12-bit shift register captures the nibble in ctr 0..2.
  - On last_cycle the word is {shift, i_fetch_rd_data}.
  - If rx_vld, the word is pushed with PC mem_pc_q, and mem_pc_q += 2 (modulo 2^16; 16'hFFFE wraps to 0).
- Overflow: a push into a full queue that is not simultaneously acked is dropped.
  - mem_pc_q is held (it still points at the dropped word).
  - pending_q is set.
  - All further words are dropped until the redirect completes.
- Branch on last_cycle:
  - Queue is flushed.
  - mem_pc_q <= i_fetch_branch_pc.
  - pending_q is set.
  - Any same-cycle push is discarded.
- Redirect: o_fetch_redirect = phase DATA & (pending_q | i_fetch_branch | overflow_now). It is combinational, so the controller sees it within the same last cycle. When taken:
  - addr_q <= branch ? i_fetch_branch_pc : mem_pc_q.
  - mem_pc_q <= that same value.
  - pending_q <= 0.
  - phase <= CMD.
- Branch outside DATA: sets pending_q. The redirect fires at the next DATA last cycle, so a fetch with a stale address is always discarded and reissued.
- Priority: branch > push/ack; a simultaneous ack and push on a full queue accepts the push.

## Timing
- Reset values:
  - o_fetch_vld = 0, o_fetch_redirect = 0, o_fetch_addr_nib = 4'h0.
  - o_fetch_instr and o_fetch_pc = 0.
  - phase = CMD, addr_q = mem_pc_q = RESET_PC, pending_q = 0, queue empty.
- Reset applied mid-operation returns to these values at the next edge. The controller is reset together with this block.
- Latency from redirect to first valid instruction: 5 words.
  - 3 words for CMD/ADDR/DUMMY.
  - 1 DATA word for sampling.
  - Push at the end of DATA word 1; o_fetch_vld is high from the next cycle.
- Queue state changes only on last_cycle edges, so o_fetch_* are stable across each 4-cycle word.

## Configuration
- IDLI_FETCH_QUEUE2_EN defined: 2-entry queue. Streaming continues while the core stalls one word.
- Undefined: 1-entry queue. Full means o_fetch_vld; overflow redirects occur more often. The ports are unchanged.

## Structure
- idli_pkg gains fetch_phase_t (CMD, ADDR, DUMMY, DATA; 2-bit) and fetch_entry_t (instr[15:0], pc[15:0]).
- One sub-module, idli_fetch_q_m: the queue, with push/pop/flush, full/empty flags and depth selected by the macro.

## Test plan
- Reset with RESET_PC=16'h0100 -> o_fetch_addr_nib reads 0,1,0,0 over the first CMD word. The first instruction, 16'hA5C3, is returned with o_fetch_pc=16'h0100 and o_fetch_vld rising 5 words after reset.
- Continuous ack of streamed words 16'h1111, 16'h2222, 16'h3333 -> same order out, PCs +2 each, no redirect.
- No ack with the 2-entry queue -> third word dropped and o_fetch_redirect high in that last cycle. The refetch address equals the dropped word's PC, and that instruction is delivered after the stall clears.
- Branch to 16'h0200 while the queue holds 2 entries -> o_fetch_vld drops the next cycle, the redirect is taken, and the next CMD word outputs nibbles 0,2,0,0.
- Branch issued during the ADDR phase -> redirect fires at the first DATA last cycle, stale data is never pushed, and the branch target is fetched.
- Streaming across 16'hFFFE -> next PC is 16'h0000.

Source files
------------

// File: rtl/idli_pkg.sv
// Shared types for the idli core's instruction fetch stage.
// Optional build macro used by the fetch queue: IDLI_FETCH_QUEUE2_EN.
package idli_pkg;

  // Phase of the SQI transaction, mirrored from the memory controller.
  typedef enum logic [1:0] {
    CMD   = 2'd0,
    ADDR  = 2'd1,
    DUMMY = 2'd2,
    DATA  = 2'd3
  } fetch_phase_t;

  // One assembled instruction together with the byte address it came from.
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } fetch_entry_t;

  // Instructions are 16 bits wide, so each sequential fetch advances the PC by 2 bytes.
  localparam logic [15:0] FETCH_PC_STEP = 16'd2;

  // Address nibble to send for a given nibble index, most-significant nibble first.
  function automatic logic [3:0] fetch_addr_nib(input logic [15:0] addr,
                                                input logic [1:0]  ctr);
    logic [3:0] nib;
    case (ctr)
      2'd0:    nib = addr[15:12];
      2'd1:    nib = addr[11:8];
      2'd2:    nib = addr[7:4];
      default: nib = addr[3:0];
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/idli_fetch_q_m.sv
// Instruction queue between fetch and decode.
// Depth is 2 when IDLI_FETCH_QUEUE2_EN is defined, otherwise 1.
// Flush beats push/pop; a push into a full queue is accepted only together with a pop.
module idli_fetch_q_m
  import idli_pkg::*;
(
  input  logic         gck,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head,
  output logic         vld,
  output logic         full
);

  logic push_eff;
  logic pop_eff;

  assign pop_eff  = pop & vld;
  assign push_eff = push & (~full | pop_eff);

`ifdef IDLI_FETCH_QUEUE2_EN

  fetch_entry_t ent0_q;
  fetch_entry_t ent1_q;
  logic [1:0]   count_q;

  // Two-slot shift queue: slot 0 is always the head, slot 1 moves down on a pop.
  always_ff @(posedge gck) begin
    if (rst) begin
      count_q <= 2'd0;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      case ({push_eff, pop_eff})
        2'b10: begin
          if (count_q == 2'd0) ent0_q <= push_entry;
          else                 ent1_q <= push_entry;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          ent0_q  <= ent1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            ent0_q <= push_entry;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = ent0_q;
  assign vld  = (count_q != 2'd0);
  assign full = (count_q == 2'd2);

`else

  fetch_entry_t ent_q;
  logic         vld_q;

  // Single-slot queue: a push replaces the entry, a lone pop empties it.
  always_ff @(posedge gck) begin
    if (rst) begin
      vld_q <= 1'b0;
      ent_q <= '0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (push_eff) begin
      vld_q <= 1'b1;
      ent_q <= push_entry;
    end else if (pop_eff) begin
      vld_q <= 1'b0;
    end
  end

  assign head = ent_q;
  assign vld  = vld_q;
  assign full = vld_q;

`endif

endmodule

// File: rtl/idli_fetch_m.sv
// Nibble-serial instruction fetch stage: supplies fetch address nibbles to the SQI
// controller, assembles returned words into instructions, queues them for decode and
// requests controller redirects on branches or queue overflow.
// Queue depth is 2 when IDLI_FETCH_QUEUE2_EN is defined, otherwise 1.
module idli_fetch_m
  import idli_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_fetch_gck,
  input  logic        i_fetch_rst,
  input  logic [1:0]  i_fetch_ctr,
  input  logic        i_fetch_ctr_last_cycle,
  input  logic [3:0]  i_fetch_rd_data,
  output logic        o_fetch_redirect,
  output logic [3:0]  o_fetch_addr_nib,
  input  logic        i_fetch_branch,
  input  logic [15:0] i_fetch_branch_pc,
  output logic        o_fetch_vld,
  output logic [15:0] o_fetch_instr,
  output logic [15:0] o_fetch_pc,
  input  logic        i_fetch_ack
);

  fetch_phase_t phase_q;
  fetch_phase_t phase_d;
  logic [15:0]  addr_q;
  logic [15:0]  mem_pc_q;
  logic         pending_q;
  logic         prev_data_q;
  logic [11:0]  shift_q;

  logic         last;
  logic         is_data;
  logic         branch_now;
  logic         rx_vld;
  logic         push_try;
  logic         push;
  logic         pop;
  logic         overflow_now;
  logic         redirect;
  logic         redirect_take;
  logic [15:0]  redirect_pc;
  logic [3:0]   addr_nib;

  fetch_entry_t push_entry;
  fetch_entry_t head;
  logic         q_vld;
  logic         q_full;

  assign last       = i_fetch_ctr_last_cycle;
  assign is_data    = (phase_q == DATA);
  assign branch_now = i_fetch_branch & last;

  // Read data lags the controller's sampling by one word, so a word is only real when
  // both this word and the previous one were DATA and no redirect is outstanding.
  assign rx_vld       = is_data & prev_data_q & ~pending_q;
  assign pop          = last & i_fetch_ack & q_vld;
  assign push_try     = last & rx_vld & ~branch_now;
  assign overflow_now = push_try & q_full & ~pop;
  assign push         = push_try & ~overflow_now;

  assign redirect_take = last & redirect;
  assign redirect_pc   = branch_now ? i_fetch_branch_pc : mem_pc_q;

  assign push_entry.instr = {shift_q, i_fetch_rd_data};
  assign push_entry.pc    = mem_pc_q;

  // Phase register tracking the controller's transaction phase.
  always_ff @(posedge i_fetch_gck) begin
    if (i_fetch_rst) phase_q <= CMD;
    else             phase_q <= phase_d;
  end

  // Phase advances once per word; DATA repeats until a redirect restarts the transaction.
  always_comb begin
    phase_d = phase_q;
    if (last) begin
      case (phase_q)
        CMD:     phase_d = ADDR;
        ADDR:    phase_d = DUMMY;
        DUMMY:   phase_d = DATA;
        default: phase_d = redirect ? CMD : DATA;
      endcase
    end
  end

  // Redirect request and address nibble driven straight to the controller.
  always_comb begin
    redirect = 1'b0;
    addr_nib = 4'h0;
    if (is_data) redirect = pending_q | branch_now | overflow_now;
    if (phase_q == CMD) addr_nib = fetch_addr_nib(addr_q, i_fetch_ctr);
  end

  // Datapath: nibble assembly, fetch/issue PC tracking and redirect bookkeeping.
  always_ff @(posedge i_fetch_gck) begin
    if (i_fetch_rst) begin
      addr_q      <= RESET_PC;
      mem_pc_q    <= RESET_PC;
      pending_q   <= 1'b0;
      prev_data_q <= 1'b0;
      shift_q     <= '0;
    end else begin
      if (last) prev_data_q <= is_data;
      if (i_fetch_ctr != 2'd3) shift_q <= {shift_q[7:0], i_fetch_rd_data};
      if (redirect_take) begin
        addr_q    <= redirect_pc;
        mem_pc_q  <= redirect_pc;
        pending_q <= 1'b0;
      end else if (branch_now) begin
        mem_pc_q  <= i_fetch_branch_pc;
        pending_q <= 1'b1;
      end else if (push) begin
        mem_pc_q  <= mem_pc_q + FETCH_PC_STEP;
      end
    end
  end

  idli_fetch_q_m u_queue (
    .gck        (i_fetch_gck),
    .rst        (i_fetch_rst),
    .push       (push),
    .pop        (pop),
    .flush      (branch_now),
    .push_entry (push_entry),
    .head       (head),
    .vld        (q_vld),
    .full       (q_full)
  );

  assign o_fetch_redirect = redirect;
  assign o_fetch_addr_nib = addr_nib;
  assign o_fetch_vld      = q_vld;
  assign o_fetch_instr    = head.instr;
  assign o_fetch_pc       = head.pc;

endmodule

// File: tb/tb_idli_fetch_m.sv
// Testbench for idli_fetch_m with RESET_PC = 16'h0100.
// Expectations follow the queue depth chosen by IDLI_FETCH_QUEUE2_EN.
module tb_idli_fetch_m;

  logic        gck;
  logic        rst;
  logic [1:0]  ctr;
  logic        last;
  logic [3:0]  rd_data;
  logic        redirect;
  logic [3:0]  addr_nib;
  logic        branch;
  logic [15:0] branch_pc;
  logic        vld;
  logic [15:0] instr;
  logic [15:0] pc;
  logic        ack;

  int compared;
  int mismatched;

  logic [3:0]  nib_seen [4];
  logic        redir_last;
  logic        vld0;
  logic [15:0] instr0;
  logic [15:0] pc0;

`ifdef IDLI_FETCH_QUEUE2_EN
  localparam int          DEPTH     = 2;
  localparam logic [15:0] DROP_PC   = 16'h010A;
  localparam logic [15:0] DROP_DATA = 16'h5555;
`else
  localparam int          DEPTH     = 1;
  localparam logic [15:0] DROP_PC   = 16'h0108;
  localparam logic [15:0] DROP_DATA = 16'h4444;
`endif

  idli_fetch_m #(.RESET_PC(16'h0100)) dut (
    .i_fetch_gck            (gck),
    .i_fetch_rst            (rst),
    .i_fetch_ctr            (ctr),
    .i_fetch_ctr_last_cycle (last),
    .i_fetch_rd_data        (rd_data),
    .o_fetch_redirect       (redirect),
    .o_fetch_addr_nib       (addr_nib),
    .i_fetch_branch         (branch),
    .i_fetch_branch_pc      (branch_pc),
    .o_fetch_vld            (vld),
    .o_fetch_instr          (instr),
    .o_fetch_pc             (pc),
    .i_fetch_ack            (ack)
  );

  initial begin
    gck = 1'b0;
    forever #5 gck = ~gck;
  end

  // Drives one 4-nibble word and records outputs a little after each falling edge.
  task automatic run_word(input logic [15:0] data, input logic ack_w,
                          input logic br, input logic [15:0] brpc);
    for (int c = 0; c < 4; c++) begin
      @(negedge gck);
      rst       = 1'b0;
      ctr       = 2'(c);
      last      = (c == 3);
      rd_data   = data[15-4*c -: 4];
      ack       = ack_w;
      branch    = br && (c == 3);
      branch_pc = brpc;
      #1;
      nib_seen[c] = addr_nib;
      if (c == 3) redir_last = redirect;
      if (c == 0) begin
        vld0   = vld;
        instr0 = instr;
        pc0    = pc;
      end
    end
  endtask

  task automatic test_reset(input string name);
    @(negedge gck);
    rst = 1'b1; ctr = 2'd0; last = 1'b0; rd_data = 4'h0;
    ack = 1'b0; branch = 1'b0; branch_pc = 16'h0;
    @(negedge gck);
    #1;
    compared++; if (vld !== 1'b0) begin mismatched++; $display("[TB] FAIL %s_vld: got %b expected 0", name, vld); end
    compared++; if (instr !== 16'h0) begin mismatched++; $display("[TB] FAIL %s_instr: got %h expected 0000", name, instr); end
    compared++; if (pc !== 16'h0) begin mismatched++; $display("[TB] FAIL %s_pc: got %h expected 0000", name, pc); end
    compared++; if (redirect !== 1'b0) begin mismatched++; $display("[TB] FAIL %s_redirect: got %b expected 0", name, redirect); end
    compared++; if (addr_nib !== 4'h0) begin mismatched++; $display("[TB] FAIL %s_addr_nib: got %h expected 0", name, addr_nib); end
  endtask

  task automatic test_first_fetch();
    logic [15:0] exp_addr;
    exp_addr = 16'h0100;
    run_word(16'hDEAD, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (nib_seen[i] !== exp_addr[15-4*i -: 4]) begin
        mismatched++; $display("[TB] FAIL reset_cmd_nib%0d: got %h expected %h", i, nib_seen[i], exp_addr[15-4*i -: 4]);
      end
    end
    run_word(16'hDEAD, 1'b0, 1'b0, 16'h0);
    run_word(16'hDEAD, 1'b0, 1'b0, 16'h0);
    run_word(16'hF00D, 1'b0, 1'b0, 16'h0);
    compared++; if (redir_last !== 1'b0) begin mismatched++; $display("[TB] FAIL first_data_redirect: got %b expected 0", redir_last); end
    run_word(16'hA5C3, 1'b0, 1'b0, 16'h0);
    compared++; if (vld0 !== 1'b0) begin mismatched++; $display("[TB] FAIL first_sample_vld: got %b expected 0", vld0); end
  endtask

  task automatic test_stream();
    logic [15:0] exp_instr [3];
    logic [15:0] exp_pc [3];
    logic [15:0] words [3];
    exp_instr[0] = 16'hA5C3; exp_instr[1] = 16'h1111; exp_instr[2] = 16'h2222;
    exp_pc[0]    = 16'h0100; exp_pc[1]    = 16'h0102; exp_pc[2]    = 16'h0104;
    words[0]     = 16'h1111; words[1]     = 16'h2222; words[2]     = 16'h3333;
    for (int k = 0; k < 3; k++) begin
      run_word(words[k], 1'b1, 1'b0, 16'h0);
      compared++; if (vld0 !== 1'b1) begin mismatched++; $display("[TB] FAIL stream%0d_vld: got %b expected 1", k, vld0); end
      compared++; if (instr0 !== exp_instr[k]) begin mismatched++; $display("[TB] FAIL stream%0d_instr: got %h expected %h", k, instr0, exp_instr[k]); end
      compared++; if (pc0 !== exp_pc[k]) begin mismatched++; $display("[TB] FAIL stream%0d_pc: got %h expected %h", k, pc0, exp_pc[k]); end
      compared++; if (redir_last !== 1'b0) begin mismatched++; $display("[TB] FAIL stream%0d_redirect: got %b expected 0", k, redir_last); end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      run_word(16'h4444 + 16'(16'h1111 * i), 1'b0, 1'b0, 16'h0);
      if (i == 0) begin
        compared++; if (instr0 !== 16'h3333 || pc0 !== 16'h0106) begin mismatched++; $display("[TB] FAIL ovf_head: got %h@%h expected 3333@0106", instr0, pc0); end
      end
      compared++;
      if (redir_last !== (i == DEPTH - 1)) begin
        mismatched++; $display("[TB] FAIL ovf_redirect%0d: got %b expected %b", i, redir_last, (i == DEPTH - 1));
      end
    end
    run_word(16'hDEAD, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (nib_seen[i] !== DROP_PC[15-4*i -: 4]) begin
        mismatched++; $display("[TB] FAIL refetch_nib%0d: got %h expected %h", i, nib_seen[i], DROP_PC[15-4*i -: 4]);
      end
    end
    run_word(16'hDEAD, 1'b1, 1'b0, 16'h0);
    compared++; if (vld0 !== 1'b1 || instr0 !== 16'h3333 || pc0 !== 16'h0106) begin mismatched++; $display("[TB] FAIL stall_head: got %b %h@%h expected 1 3333@0106", vld0, instr0, pc0); end
    run_word(16'hDEAD, 1'b1, 1'b0, 16'h0);
`ifdef IDLI_FETCH_QUEUE2_EN
    compared++; if (vld0 !== 1'b1 || instr0 !== 16'h4444 || pc0 !== 16'h0108) begin mismatched++; $display("[TB] FAIL stall_head2: got %b %h@%h expected 1 4444@0108", vld0, instr0, pc0); end
`else
    compared++; if (vld0 !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_empty: got %b expected 0", vld0); end
`endif
    run_word(16'hDEAD, 1'b0, 1'b0, 16'h0);
    compared++; if (vld0 !== 1'b0) begin mismatched++; $display("[TB] FAIL drained_vld: got %b expected 0", vld0); end
    run_word(DROP_DATA, 1'b0, 1'b0, 16'h0);
    compared++; if (redir_last !== 1'b0) begin mismatched++; $display("[TB] FAIL refetch_redirect: got %b expected 0", redir_last); end
  endtask

  task automatic test_branch();
`ifdef IDLI_FETCH_QUEUE2_EN
    run_word(16'h7777, 1'b0, 1'b0, 16'h0);
    compared++; if (redir_last !== 1'b0) begin mismatched++; $display("[TB] FAIL fill_redirect: got %b expected 0", redir_last); end
`endif
    run_word(16'h8888, 1'b0, 1'b1, 16'h0200);
    compared++; if (vld0 !== 1'b1 || instr0 !== DROP_DATA || pc0 !== DROP_PC) begin mismatched++; $display("[TB] FAIL refetch_head: got %b %h@%h expected 1 %h@%h", vld0, instr0, pc0, DROP_DATA, DROP_PC); end
    compared++; if (redir_last !== 1'b1) begin mismatched++; $display("[TB] FAIL branch_redirect: got %b expected 1", redir_last); end
    run_word(16'hDEAD, 1'b0, 1'b0, 16'h0);
    compared++; if (vld0 !== 1'b0) begin mismatched++; $display("[TB] FAIL branch_flush_vld: got %b expected 0", vld0); end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (nib_seen[i] !== ((i == 1) ? 4'h2 : 4'h0)) begin
        mismatched++; $display("[TB] FAIL branch_nib%0d: got %h expected %h", i, nib_seen[i], ((i == 1) ? 4'h2 : 4'h0));
      end
    end
    run_word(16'hDEAD, 1'b0, 1'b0, 16'h0);
    run_word(16'hDEAD, 1'b0, 1'b0, 16'h0);
    run_word(16'hBAD0, 1'b0, 1'b0, 16'h0);
    run_word(16'hBEEF, 1'b0, 1'b0, 16'h0);
    compared++; if (vld0 !== 1'b0) begin mismatched++; $display("[TB] FAIL branch_pre_vld: got %b expected 0", vld0); end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_addr;
    exp_addr = 16'hFFFC;
    run_word(16'hDEAD, 1'b1, 1'b1, 16'hFFFC);
    compared++; if (vld0 !== 1'b1 || instr0 !== 16'hBEEF || pc0 !== 16'h0200) begin mismatched++; $display("[TB] FAIL branch_target_head: got %b %h@%h expected 1 BEEF@0200", vld0, instr0, pc0); end
    run_word(16'hDEAD, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (nib_seen[i] !== exp_addr[15-4*i -: 4]) begin
        mismatched++; $display("[TB] FAIL wrap_nib%0d: got %h expected %h", i, nib_seen[i], exp_addr[15-4*i -: 4]);
      end
    end
    run_word(16'hDEAD, 1'b0, 1'b0, 16'h0);
    run_word(16'hDEAD, 1'b0, 1'b0, 16'h0);
    run_word(16'hDEAD, 1'b0, 1'b0, 16'h0);
    run_word(16'h0AAA, 1'b0, 1'b0, 16'h0);
    run_word(16'h0BBB, 1'b1, 1'b0, 16'h0);
    compared++; if (instr0 !== 16'h0AAA || pc0 !== 16'hFFFC) begin mismatched++; $display("[TB] FAIL wrap_head0: got %h@%h expected 0AAA@FFFC", instr0, pc0); end
    run_word(16'h0CCC, 1'b1, 1'b0, 16'h0);
    compared++; if (instr0 !== 16'h0BBB || pc0 !== 16'hFFFE) begin mismatched++; $display("[TB] FAIL wrap_head1: got %h@%h expected 0BBB@FFFE", instr0, pc0); end
    run_word(16'hDEAD, 1'b1, 1'b0, 16'h0);
    compared++; if (vld0 !== 1'b1 || instr0 !== 16'h0CCC || pc0 !== 16'h0000) begin mismatched++; $display("[TB] FAIL wrap_head2: got %b %h@%h expected 1 0CCC@0000", vld0, instr0, pc0); end
  endtask

  task automatic test_branch_addr();
    test_reset("mid_reset");
    run_word(16'hDEAD, 1'b0, 1'b0, 16'h0);
    run_word(16'hDEAD, 1'b0, 1'b1, 16'h0300);
    compared++; if (redir_last !== 1'b0) begin mismatched++; $display("[TB] FAIL addr_branch_redirect: got %b expected 0", redir_last); end
    run_word(16'hDEAD, 1'b0, 1'b0, 16'h0);
    run_word(16'h5A5A, 1'b0, 1'b0, 16'h0);
    compared++; if (redir_last !== 1'b1) begin mismatched++; $display("[TB] FAIL pending_redirect: got %b expected 1", redir_last); end
    run_word(16'h6B6B, 1'b0, 1'b0, 16'h0);
    compared++; if (vld0 !== 1'b0) begin mismatched++; $display("[TB] FAIL stale_vld: got %b expected 0", vld0); end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (nib_seen[i] !== ((i == 1) ? 4'h3 : 4'h0)) begin
        mismatched++; $display("[TB] FAIL addr_branch_nib%0d: got %h expected %h", i, nib_seen[i], ((i == 1) ? 4'h3 : 4'h0));
      end
    end
    run_word(16'hDEAD, 1'b0, 1'b0, 16'h0);
    run_word(16'hDEAD, 1'b0, 1'b0, 16'h0);
    run_word(16'h7C7C, 1'b0, 1'b0, 16'h0);
    run_word(16'h1234, 1'b0, 1'b0, 16'h0);
    compared++; if (vld0 !== 1'b0) begin mismatched++; $display("[TB] FAIL addr_branch_pre_vld: got %b expected 0", vld0); end
    run_word(16'hDEAD, 1'b0, 1'b0, 16'h0);
    compared++; if (vld0 !== 1'b1 || instr0 !== 16'h1234 || pc0 !== 16'h0300) begin mismatched++; $display("[TB] FAIL addr_branch_head: got %b %h@%h expected 1 1234@0300", vld0, instr0, pc0); end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b1; ctr = 2'd0; last = 1'b0; rd_data = 4'h0;
    ack = 1'b0; branch = 1'b0; branch_pc = 16'h0;
    test_reset("reset");
    test_first_fetch();
    test_stream();
    test_overflow();
    test_branch();
    test_wrap();
    test_branch_addr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
